cache_rd_arbiter: RTL and testbench
===================================

CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORD_NUM, default 4, meaning 32-bit words per cache line (burst length for cached reads).
REQ-002 SHALL have port clk_g  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports ic_rd_req/dc_rd_req  input  1  per-requester read request (index 0 = icache, 1 = dcache).
REQ-005 SHALL have ports ic_rd_addr/dc_rd_addr  input  32  read address; line-aligned when cached.
REQ-006 SHALL have ports ic_rd_uncache/dc_rd_uncache  input  1  1 = single-word uncached read.
REQ-007 SHALL have ports ic_rd_rdy/dc_rd_rdy  output  1  one-cycle pulse: request accepted.
REQ-008 SHALL have ports ic_ret_valid/dc_ret_valid  output  1  one-cycle pulse: ret_data valid for that requester.
REQ-009 SHALL have port ret_data  output  128  shared return line/word.
REQ-010 SHALL have ports arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 (outputs) and arready 1 (input)  AXI4 read-address channel.
REQ-011 SHALL have ports rdata 32, rlast 1, rvalid 1 (inputs) and rready 1 (output)  AXI4 read-data channel; rid/rresp unused.

Function
REQ-012 SHALL implement FSM IDLE -> ADDR -> DATA -> DONE -> IDLE; exactly one transaction outstanding.
REQ-013 In IDLE with any rd_req high: grant per round-robin pointer, latch addr/uncache/grantee, go to ADDR next cycle.
REQ-014 Round-robin: on simultaneous requests, grant the requester NOT granted last; pointer resets to "last = dcache" (icache wins first tie).
REQ-015 In ADDR: arvalid=1; arid = 0 (icache) / 1 (dcache); araddr = latched addr; arsize=3'b010; arburst=INCR (2'b01) cached, FIXED (2'b00) uncached; arlen = LINE_WORD_NUM-1 cached, 0 uncached.
REQ-016 AR fields SHALL stay stable while arvalid=1 and arready=0.
REQ-017 On arvalid&&arready: pulse grantee's rd_rdy that same cycle, clear arvalid, go to DATA.
REQ-018 In DATA: rready=1; each rvalid beat writes rdata into ret_data[(k+1)*32-1:k*32] for cached beat k (k from 0); beat counter width $clog2(LINE_WORD_NUM), no wrap beyond last index (saturates).
REQ-019 Uncached: the single beat SHALL be placed in ret_data[127:96]; other bits 0.
REQ-020 Beat with rlast=1 SHALL end DATA regardless of count -> DONE; unwritten words of the line buffer SHALL read 0 (buffer cleared at grant).
REQ-021 In DONE: pulse grantee's ret_valid for exactly one cycle with ret_data valid that cycle; go to IDLE. Latency rlast beat -> ret_valid = 1 cycle.
REQ-022 ret_data SHALL hold its value until the next grant clears it.
REQ-023 Requests arriving in DONE/ADDR/DATA are not sampled; they are evaluated only in IDLE (min 4 cycles between grants).
REQ-024 Non-granted requester's rd_rdy and ret_valid SHALL stay 0 throughout.
REQ-025 rd_req deasserted after grant SHALL NOT abort the transaction.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, arvalid=0, rready=0, all rd_rdy/ret_valid=0, ret_data=0, beat counter=0, round-robin pointer=dcache; applies mid-transaction (transaction abandoned, no ret_valid).

Verification
REQ-027 Icache cached read 0x1fc0_0010, arready immediate, rdata 0xA,0xB,0xC,0xD (rlast on 4th) -> arlen=3, arburst=1, ic_rd_rdy 1 pulse, ic_ret_valid 1 cycle after 4th beat, ret_data=0x0000000D_0000000C_0000000B_0000000A.
REQ-028 Dcache uncached read 0xbfaf_8000, rdata 0x12345678 rlast -> arlen=0, arid=1, dc_ret_valid with ret_data[127:96]=0x12345678, rest 0.
REQ-029 Both rd_req high from reset, continuously -> grant order icache, dcache, icache, dcache.
REQ-030 arready held low 5 cycles -> arvalid/araddr/arlen stable 5 cycles, rd_rdy only in handshake cycle.
REQ-031 rst asserted during beat 2 of a cached burst -> next cycle IDLE, rready=0, no ret_valid; next request served normally.
REQ-032 Cached burst with rlast on beat 2 -> ret_valid next cycle, words 2-3 of ret_data = 0.

Source files
------------

// File: rtl/cache_rd_arbiter_if.sv
// Handshake bundles for the cache read arbiter: requester side (icache/dcache)
// and the AXI4 read address/data channels.

interface cache_rd_if;
   logic         ic_rd_req;
   logic         dc_rd_req;
   logic [31:0]  ic_rd_addr;
   logic [31:0]  dc_rd_addr;
   logic         ic_rd_uncache;
   logic         dc_rd_uncache;
   logic         ic_rd_rdy;
   logic         dc_rd_rdy;
   logic         ic_ret_valid;
   logic         dc_ret_valid;
   logic [127:0] ret_data;

   modport master (
      output ic_rd_req, dc_rd_req, ic_rd_addr, dc_rd_addr, ic_rd_uncache, dc_rd_uncache,
      input  ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, ret_data
   );

   modport slave (
      input  ic_rd_req, dc_rd_req, ic_rd_addr, dc_rd_addr, ic_rd_uncache, dc_rd_uncache,
      output ic_rd_rdy, dc_rd_rdy, ic_ret_valid, dc_ret_valid, ret_data
   );
endinterface

interface axi_rd_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rdata, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rdata, rlast, rvalid
   );
endinterface

// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter funnelling icache/dcache line and uncached reads onto one
// AXI4 read port, one transaction at a time, returning the assembled line.

module cache_rd_arbiter #(
   parameter int unsigned LINE_WORD_NUM = 4
) (
   input  logic       clk_g,
   input  logic       rst,
   cache_rd_if.slave  req,
   axi_rd_if.master   axi
);

   localparam int unsigned BEAT_W   = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
   localparam int unsigned IDX_W    = 7;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORD_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t             state;
   logic               grant_dc;
   logic               last_dc;
   logic               uncache_q;
   logic [BEAT_W-1:0]  beat;

   logic               any_req_c;
   logic               pick_dc_c;
   logic               pick_unc_c;

   // dcache wins only when alone or when icache held the previous grant
   assign any_req_c  = req.ic_rd_req | req.dc_rd_req;
   assign pick_dc_c  = req.dc_rd_req & (~req.ic_rd_req | ~last_dc);
   assign pick_unc_c = pick_dc_c ? req.dc_rd_uncache : req.ic_rd_uncache;

   // Accept pulse follows the AR handshake in the same cycle
   assign req.ic_rd_rdy = axi.arvalid & axi.arready & ~grant_dc;
   assign req.dc_rd_rdy = axi.arvalid & axi.arready &  grant_dc;

   always_ff @(posedge clk_g) begin
      if (rst) begin
         state            <= S_IDLE;
         grant_dc         <= 1'b0;
         last_dc          <= 1'b1;
         uncache_q        <= 1'b0;
         beat             <= '0;
         axi.arid         <= '0;
         axi.araddr       <= '0;
         axi.arlen        <= '0;
         axi.arsize       <= '0;
         axi.arburst      <= '0;
         axi.arvalid      <= 1'b0;
         axi.rready       <= 1'b0;
         req.ic_ret_valid <= 1'b0;
         req.dc_ret_valid <= 1'b0;
         req.ret_data     <= '0;
      end else begin
         req.ic_ret_valid <= 1'b0;
         req.dc_ret_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req_c) begin
                  grant_dc     <= pick_dc_c;
                  last_dc      <= pick_dc_c;
                  uncache_q    <= pick_unc_c;
                  axi.arid     <= pick_dc_c ? 4'd1 : 4'd0;
                  axi.araddr   <= pick_dc_c ? req.dc_rd_addr : req.ic_rd_addr;
                  axi.arlen    <= pick_unc_c ? 8'd0 : 8'(LINE_WORD_NUM - 1);
                  axi.arsize   <= 3'b010;
                  axi.arburst  <= pick_unc_c ? 2'b00 : 2'b01;
                  axi.arvalid  <= 1'b1;
                  req.ret_data <= '0;
                  beat         <= '0;
                  state        <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (axi.arready) begin
                  axi.arvalid <= 1'b0;
                  axi.rready  <= 1'b1;
                  state       <= S_DATA;
               end
            end
            S_DATA: begin
               if (axi.rvalid) begin
                  if (uncache_q) begin
                     req.ret_data[127:96] <= axi.rdata;
                  end else begin
                     req.ret_data[IDX_W'(beat) * IDX_W'(32) +: 32] <= axi.rdata;
                  end
                  if (beat != LAST_BEAT) begin
                     beat <= beat + 1'b1;
                  end
                  if (axi.rlast) begin
                     axi.rready       <= 1'b0;
                     req.ic_ret_valid <= ~grant_dc;
                     req.dc_ret_valid <=  grant_dc;
                     state            <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: cached/uncached reads, AR backpressure,
// short burst, mid-burst reset and round-robin ordering.

module tb_cache_rd_arbiter;

   logic clk_g;
   logic rst;
   int   passed;
   int   total;

   cache_rd_if req_if ();
   axi_rd_if   axi_if ();

   cache_rd_arbiter #(.LINE_WORD_NUM(4)) dut (
      .clk_g (clk_g),
      .rst   (rst),
      .req   (req_if),
      .axi   (axi_if)
   );

   initial clk_g = 1'b0;
   always #5 clk_g = ~clk_g;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk_g);
   endtask

   task automatic beat(input logic [31:0] d, input logic last);
      axi_if.rvalid = 1'b1;
      axi_if.rdata  = d;
      axi_if.rlast  = last;
      tick();
      axi_if.rvalid = 1'b0;
      axi_if.rlast  = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst    = 1'b1;
      req_if.ic_rd_req = 1'b0;  req_if.dc_rd_req = 1'b0;
      req_if.ic_rd_addr = '0;   req_if.dc_rd_addr = '0;
      req_if.ic_rd_uncache = 1'b0; req_if.dc_rd_uncache = 1'b0;
      axi_if.arready = 1'b0; axi_if.rdata = '0; axi_if.rlast = 1'b0; axi_if.rvalid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_arvalid", 128'(axi_if.arvalid), 128'd0);
      chk("rst_rready", 128'(axi_if.rready), 128'd0);
      chk("rst_ret_data", req_if.ret_data, 128'd0);
      chk("rst_ret_valid", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'd0);

      // icache cached line read, immediate arready
      req_if.ic_rd_req = 1'b1; req_if.ic_rd_addr = 32'h1fc0_0010; req_if.ic_rd_uncache = 1'b0;
      axi_if.arready = 1'b1;
      tick();
      req_if.ic_rd_req = 1'b0;
      #1;
      chk("c_arvalid", 128'(axi_if.arvalid), 128'd1);
      chk("c_araddr", 128'(axi_if.araddr), 128'h1fc0_0010);
      chk("c_arlen", 128'(axi_if.arlen), 128'd3);
      chk("c_arburst", 128'(axi_if.arburst), 128'd1);
      chk("c_arsize", 128'(axi_if.arsize), 128'd2);
      chk("c_arid", 128'(axi_if.arid), 128'd0);
      chk("c_rd_rdy", 128'({req_if.ic_rd_rdy, req_if.dc_rd_rdy}), 128'b10);
      tick(); #1;
      chk("c_arvalid_clr", 128'(axi_if.arvalid), 128'd0);
      chk("c_rready", 128'(axi_if.rready), 128'd1);
      chk("c_rd_rdy_clr", 128'(req_if.ic_rd_rdy), 128'd0);
      beat(32'hA, 1'b0);
      beat(32'hB, 1'b0);
      beat(32'hC, 1'b0);
      beat(32'hD, 1'b1);
      #1;
      chk("c_ret_valid", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'b10);
      chk("c_ret_data", req_if.ret_data, 128'h0000000D_0000000C_0000000B_0000000A);
      chk("c_rready_clr", 128'(axi_if.rready), 128'd0);
      tick(); #1;
      chk("c_ret_valid_clr", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'b00);
      chk("c_ret_data_hold", req_if.ret_data, 128'h0000000D_0000000C_0000000B_0000000A);

      // dcache uncached single-word read
      req_if.dc_rd_req = 1'b1; req_if.dc_rd_addr = 32'hbfaf_8000; req_if.dc_rd_uncache = 1'b1;
      tick();
      req_if.dc_rd_req = 1'b0;
      #1;
      chk("u_arid", 128'(axi_if.arid), 128'd1);
      chk("u_arlen", 128'(axi_if.arlen), 128'd0);
      chk("u_arburst", 128'(axi_if.arburst), 128'd0);
      chk("u_araddr", 128'(axi_if.araddr), 128'hbfaf_8000);
      chk("u_rd_rdy", 128'({req_if.ic_rd_rdy, req_if.dc_rd_rdy}), 128'b01);
      chk("u_cleared", req_if.ret_data, 128'd0);
      tick();
      beat(32'h1234_5678, 1'b1);
      #1;
      chk("u_ret_valid", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'b01);
      chk("u_ret_data", req_if.ret_data, {32'h1234_5678, 96'd0});
      tick(); #1;
      chk("u_ret_valid_clr", 128'(req_if.dc_ret_valid), 128'd0);

      // icache cached read with arready held low for 5 cycles, rlast on beat 2
      req_if.ic_rd_req = 1'b1; req_if.ic_rd_addr = 32'h0000_0100; req_if.ic_rd_uncache = 1'b0;
      axi_if.arready = 1'b0;
      tick();
      req_if.ic_rd_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp_stable%0d", i),
             {47'd0, axi_if.arvalid, axi_if.araddr, axi_if.arlen, 38'd0, req_if.ic_rd_rdy, req_if.dc_rd_rdy},
             {47'd0, 1'b1, 32'h0000_0100, 8'd3, 38'd0, 2'b00});
         tick();
      end
      axi_if.arready = 1'b1;
      #1;
      chk("bp_rd_rdy", 128'({req_if.ic_rd_rdy, req_if.dc_rd_rdy}), 128'b10);
      tick();
      beat(32'h11, 1'b0);
      beat(32'h22, 1'b1);
      #1;
      chk("short_ret_valid", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'b10);
      chk("short_ret_data", req_if.ret_data, {64'd0, 32'h22, 32'h11});
      tick();

      // dcache cached read, reset asserted on the second beat
      req_if.dc_rd_req = 1'b1; req_if.dc_rd_addr = 32'h0000_0200; req_if.dc_rd_uncache = 1'b0;
      tick();
      req_if.dc_rd_req = 1'b0;
      tick();
      beat(32'h1, 1'b0);
      rst = 1'b1;
      beat(32'h2, 1'b0);
      rst = 1'b0;
      #1;
      chk("mrst_rready", 128'(axi_if.rready), 128'd0);
      chk("mrst_arvalid", 128'(axi_if.arvalid), 128'd0);
      chk("mrst_ret_data", req_if.ret_data, 128'd0);
      tick(); #1;
      chk("mrst_no_ret_valid", 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}), 128'b00);
      chk("mrst_idle", 128'(axi_if.arvalid), 128'd0);

      // both requesters held high: alternate starting with icache
      req_if.ic_rd_req = 1'b1; req_if.ic_rd_addr = 32'h0000_1000; req_if.ic_rd_uncache = 1'b0;
      req_if.dc_rd_req = 1'b1; req_if.dc_rd_addr = 32'h0000_2000; req_if.dc_rd_uncache = 1'b0;
      for (int t = 0; t < 4; t++) begin
         logic exp_dc;
         exp_dc = (t % 2) == 1;
         tick(); #1;
         chk($sformatf("rr%0d_arid", t), 128'(axi_if.arid), exp_dc ? 128'd1 : 128'd0);
         chk($sformatf("rr%0d_rd_rdy", t), 128'({req_if.ic_rd_rdy, req_if.dc_rd_rdy}),
             exp_dc ? 128'b01 : 128'b10);
         tick();
         beat(32'h100 + 32'(t), 1'b1);
         #1;
         chk($sformatf("rr%0d_ret_valid", t), 128'({req_if.ic_ret_valid, req_if.dc_ret_valid}),
             exp_dc ? 128'b01 : 128'b10);
         chk($sformatf("rr%0d_ret_data", t), req_if.ret_data, 128'(32'h100 + 32'(t)));
         tick();
      end
      req_if.ic_rd_req = 1'b0;
      req_if.dc_rd_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
